// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// pico_pkg: shared pico ALU types (datapath width, operation and flag encodings)
// alu_share_ctrl: round-robin controller that time-shares one combinational
// pico ALU between R requesters.
//
// Ports (alu_share_ctrl):
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   per-requester request handshake (ready one-hot)
//   req_op_i/req_a_i/req_b_i  per-requester operation and operands
//   resp_valid_o/resp_ready_i one-hot response handshake
//   resp_r_o/resp_flags_o     shared result and flags, held until accepted
//   alu_op_o/alu_a_o/alu_b_o  registered ALU inputs
//   alu_r_i/alu_flags_i       ALU result and flags
//   busy_o                    high whenever the controller is not idle
// -----------------------------------------------------------------------------
package pico_pkg;
  localparam int N = 8;

  typedef enum logic [3:0] {
    F_A   = 4'd0,
    F_B   = 4'd1,
    F_ADD = 4'd2,
    F_SUB = 4'd3,
    F_AND = 4'd4,
    F_OR  = 4'd5,
    F_XOR = 4'd6,
    F_MUL = 4'd7
  } funcALU;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flagsALU;
endpackage

module alu_share_ctrl #(
  parameter int N = pico_pkg::N,
  parameter int R = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [R-1:0]             req_valid_i,
  output logic [R-1:0]             req_ready_o,
  input  pico_pkg::funcALU         req_op_i [R],
  input  logic [N-1:0]             req_a_i  [R],
  input  logic [N-1:0]             req_b_i  [R],
  output logic [R-1:0]             resp_valid_o,
  input  logic [R-1:0]             resp_ready_i,
  output logic [N-1:0]             resp_r_o,
  output pico_pkg::flagsALU        resp_flags_o,
  output pico_pkg::funcALU         alu_op_o,
  output logic [N-1:0]             alu_a_o,
  output logic [N-1:0]             alu_b_o,
  input  logic [N-1:0]             alu_r_i,
  input  pico_pkg::flagsALU        alu_flags_i,
  output logic                     busy_o
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     gnt_q;
  logic [IW-1:0]     gnt_s;
  logic              found_s;
  logic              transfer_s;
  pico_pkg::funcALU  op_q;
  logic [N-1:0]      a_q, b_q;
  logic [N-1:0]      r_q;
  pico_pkg::flagsALU flags_q;
  logic [R-1:0]      resp_valid_q;
  logic              busy_q;

  // Round-robin search: first valid requester starting at ptr, wrapping at R
  // (R need not be a power of two, so the wrap is an explicit subtract).
  always_comb begin
    found_s = 1'b0;
    gnt_s   = '0;
    for (int k = 0; k < R; k++) begin
      int            idx;
      logic [IW-1:0] cand;
      idx = int'(ptr_q) + k;
      if (idx >= R) begin
        idx = idx - R;
      end else begin
        idx = idx;
      end
      cand = IW'(idx);
      if (!found_s && req_valid_i[cand]) begin
        found_s = 1'b1;
        gnt_s   = cand;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic and the combinational request accept.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    transfer_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Ready is held low while reset is asserted so nothing is accepted
        // on the edge that reset consumes.
        if (found_s && !rst_i) begin
          req_ready_o[gnt_s] = 1'b1;
          transfer_s         = 1'b1;
          state_d            = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i[gnt_q]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, arbitration pointer, operand capture, result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      ptr_q        <= '0;
      gnt_q        <= '0;
      op_q         <= pico_pkg::F_A;
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      flags_q      <= '0;
      resp_valid_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      if (transfer_s) begin
        gnt_q <= gnt_s;
        ptr_q <= (gnt_s == IW'(R - 1)) ? '0 : gnt_s + 1'b1;
        op_q  <= req_op_i[gnt_s];
        a_q   <= req_a_i[gnt_s];
        b_q   <= req_b_i[gnt_s];
      end
      // ALU is fed from a_q/b_q/op_q for the whole EXEC cycle.
      if (state_q == S_EXEC) begin
        r_q          <= alu_r_i;
        flags_q      <= alu_flags_i;
        resp_valid_q <= R'(1) << gnt_q;
      end else if ((state_q == S_RESP) && resp_ready_i[gnt_q]) begin
        resp_valid_q <= '0;
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_r_o     = r_q;
  assign resp_flags_o = flags_q;
  assign alu_op_o     = op_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural pico ALU attached.
module tb_alu_share_ctrl;
  import pico_pkg::*;

  localparam int N = 8;
  localparam int R = 3;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] r;
    logic [3:0] flags;
  } exp_t;

  logic             clk;
  logic             rst_i;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  funcALU           req_op [R];
  logic [N-1:0]     req_a  [R];
  logic [N-1:0]     req_b  [R];
  logic [R-1:0]     resp_valid;
  logic [R-1:0]     resp_ready;
  logic [N-1:0]     resp_r;
  flagsALU          resp_flags;
  funcALU           alu_op;
  logic [N-1:0]     alu_a, alu_b, alu_r;
  flagsALU          alu_flags;
  logic             busy;

  exp_t sb [$];
  exp_t mon_e;
  int   vec_cnt;
  int   err_cnt;

  alu_share_ctrl #(.N(N), .R(R)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_r_o     (resp_r),
    .resp_flags_o (resp_flags),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_r_i      (alu_r),
    .alu_flags_i  (alu_flags),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pico ALU: flags always come from the add/sub path.
  always_comb begin
    logic [8:0] s9;
    logic [7:0] s;
    if (alu_op == F_SUB) s9 = {1'b0, alu_a} - {1'b0, alu_b};
    else                 s9 = {1'b0, alu_a} + {1'b0, alu_b};
    s = s9[7:0];
    alu_flags.carry    = s9[8];
    alu_flags.overflow = (alu_op == F_SUB)
                       ? ((alu_a[7] != alu_b[7]) && (s[7] != alu_a[7]))
                       : ((alu_a[7] == alu_b[7]) && (s[7] != alu_a[7]));
    alu_flags.zero     = (s == 8'h00);
    alu_flags.negative = s[7];
    case (alu_op)
      F_A:     alu_r = alu_a;
      F_B:     alu_r = alu_b;
      F_ADD:   alu_r = s;
      F_SUB:   alu_r = s;
      F_AND:   alu_r = alu_a & alu_b;
      F_OR:    alu_r = alu_a | alu_b;
      F_XOR:   alu_r = alu_a ^ alu_b;
      F_MUL:   alu_r = 8'(alu_a * alu_b);
      default: alu_r = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_i && ((resp_valid & resp_ready) != 3'b000)) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_resp: got valid %b expected no response", resp_valid);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(3'b001 << mon_e.idx));
        chk("resp_r",     32'(resp_r),     32'(mon_e.r));
        chk("resp_flags", 32'(resp_flags), 32'(mon_e.flags));
      end
    end
  end

  // One clock: sample handshakes before the edge, retire accepted requests after.
  task automatic tick();
    logic [R-1:0] xfer;
    @(negedge clk);
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~xfer;
    #1;
  endtask

  task automatic set_req(input int i, input funcALU op, input logic [7:0] a, input logic [7:0] b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] r, input logic [3:0] f);
    exp_t e;
    e.idx = idx; e.r = r; e.flags = f;
    sb.push_back(e);
  endtask

  task automatic run_until_done(input string name);
    int n;
    n = 0;
    tick();
    while ((busy || (req_valid != 3'b000) || (sb.size() != 0)) && (n < 60)) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s_timeout: got busy %b pending %0d expected idle", name, busy, sb.size());
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst_i      = 1'b1;
    req_valid  = 3'b000;
    resp_ready = 3'b111;
    for (int i = 0; i < R; i++) set_req(i, F_A, 8'h00, 8'h00);

    // Reset values, with all requesters valid to show ready stays low
    tick();
    req_valid = 3'b111;
    tick();
    chk("rst_req_ready",  32'(req_ready),  32'(3'b000));
    chk("rst_resp_valid", 32'(resp_valid), 32'(3'b000));
    chk("rst_resp_r",     32'(resp_r),     32'(8'h00));
    chk("rst_flags",      32'(resp_flags), 32'(4'b0000));
    chk("rst_busy",       32'(busy),       32'(1'b0));
    chk("rst_alu_op",     32'(alu_op),     32'(F_A));
    chk("rst_alu_a",      32'(alu_a),      32'(8'h00));
    chk("rst_alu_b",      32'(alu_b),      32'(8'h00));
    req_valid = 3'b000;
    rst_i = 1'b0;

    // Single ADD with overflow: 0x7F + 0x01 = 0x80, C0 V1 Z0 N1
    set_req(0, F_ADD, 8'h7F, 8'h01);
    push(2'd0, 8'h80, 4'b0101);
    req_valid = 3'b001;
    #1;
    chk("add_ready_c0", 32'(req_ready), 32'(3'b001));
    tick();
    chk("add_busy_c1",  32'(busy),       32'(1'b1));
    chk("add_nresp_c1", 32'(resp_valid), 32'(3'b000));
    chk("add_alu_op",   32'(alu_op),     32'(F_ADD));
    chk("add_alu_a",    32'(alu_a),      32'(8'h7F));
    tick();
    chk("add_resp_c2",  32'(resp_valid), 32'(3'b001));
    run_until_done("add");

    // SUB to zero on req1: 5 - 5 = 0, C0 V0 Z1 N0
    set_req(1, F_SUB, 8'h05, 8'h05);
    push(2'd1, 8'h00, 4'b0010);
    req_valid = 3'b010;
    run_until_done("sub");

    // Round robin from a fresh pointer: 0,1,2 then 0,2
    do_reset();
    set_req(0, F_XOR, 8'h0F, 8'hF0);
    set_req(1, F_XOR, 8'h3C, 8'h3C);
    set_req(2, F_XOR, 8'h80, 8'h80);
    push(2'd0, 8'hFF, 4'b0001);
    push(2'd1, 8'h00, 4'b0000);
    push(2'd2, 8'h00, 4'b1110);
    req_valid = 3'b111;
    run_until_done("rr3");
    push(2'd0, 8'hFF, 4'b0001);
    push(2'd2, 8'h00, 4'b1110);
    req_valid = 3'b101;
    run_until_done("rr_wrap");

    // Response backpressure on req2 MUL 3*5; resp_ready[0] must not count
    set_req(2, F_MUL, 8'h03, 8'h05);
    push(2'd2, 8'h0F, 4'b0000);
    resp_ready = 3'b001;
    req_valid  = 3'b100;
    tick();
    tick();
    req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_resp_valid", 32'(resp_valid), 32'(3'b100));
      chk("bp_resp_r",     32'(resp_r),     32'(8'h0F));
      chk("bp_req_ready",  32'(req_ready),  32'(3'b000));
      chk("bp_busy",       32'(busy),       32'(1'b1));
      tick();
    end
    req_valid[1] = 1'b0;
    resp_ready   = 3'b111;
    run_until_done("bp");

    // Withdrawn request: req1 valid only while req0 sits in RESP
    set_req(0, F_ADD, 8'h01, 8'h02);
    push(2'd0, 8'h03, 4'b0000);
    resp_ready = 3'b110;
    req_valid  = 3'b001;
    tick();
    tick();
    req_valid[1] = 1'b1;
    #1;
    chk("wd_req_ready", 32'(req_ready), 32'(3'b000));
    tick();
    tick();
    req_valid[1] = 1'b0;
    resp_ready   = 3'b111;
    run_until_done("wd");
    for (int c = 0; c < 6; c++) tick();
    chk("wd_no_resp", 32'(resp_valid), 32'(3'b000));

    // Unused encoding passes through; the ALU returns 0 and flags from add path
    set_req(0, funcALU'(4'hF), 8'h01, 8'h01);
    push(2'd0, 8'h00, 4'b0000);
    req_valid = 3'b001;
    tick();
    chk("inv_alu_op", 32'(alu_op), 32'(4'hF));
    run_until_done("inv");

    // Reset during EXEC of a req1 operation (pointer is 1 at this point)
    set_req(1, F_XOR, 8'h3C, 8'h3C);
    set_req(2, F_XOR, 8'h80, 8'h80);
    req_valid = 3'b010;
    tick();
    chk("mid_in_exec", 32'(busy), 32'(1'b1));
    rst_i = 1'b1;
    tick();
    req_valid = 3'b110;
    #1;
    chk("mid_resp_valid", 32'(resp_valid), 32'(3'b000));
    chk("mid_busy",       32'(busy),       32'(1'b0));
    chk("mid_alu_a",      32'(alu_a),      32'(8'h00));
    chk("mid_alu_op",     32'(alu_op),     32'(F_A));
    chk("mid_req_ready",  32'(req_ready),  32'(3'b000));
    rst_i = 1'b0;
    // Pointer back at 0: req1 wins over req2
    push(2'd1, 8'h00, 4'b0000);
    push(2'd2, 8'h00, 4'b1110);
    run_until_done("post_rst");
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
